fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
Pipelined successor to the single-cycle control path. The block owns the PC register, drives the instruction-memory address, and captures each fetched instruction into an IF/ID pipeline register. It then decodes the registered instruction into full RV32I control signals and a sign-extended immediate. It supports stall and flush from downstream hazard and branch logic, and sits between instruction memory and the register file / ID/EX register.

Parameters:
ADDRESS_WIDTH, 32, width of the PC and the instruction-memory address
DATA_WIDTH, 32, instruction and immediate width (fixed at 32 for RV32I; other values unsupported)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  single clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hold the PC and the IF/ID register
flush_i  input  1  redirect: load pc_target_i and squash IF/ID
pc_target_i  input  ADDRESS_WIDTH  redirect target (branch/jump from EX)
imem_addr_o  output  ADDRESS_WIDTH  current PC, to instruction memory
imem_rdata_i  input  DATA_WIDTH  instruction at imem_addr_o, combinational read
id_valid_o  output  1  IF/ID holds a real instruction
id_pc_o  output  ADDRESS_WIDTH  PC of the decoded instruction
id_pc_plus4_o  output  ADDRESS_WIDTH  id_pc_o + 4
id_rs1_o, id_rs2_o, id_rd_o  output  5 each  register fields
id_imm_o  output  DATA_WIDTH  sign-extended immediate
RegWrite  output  1  register-file write enable
MemWrite  output  1  data-memory write enable
ResultSrc  output  2  00 ALU, 01 memory, 10 PC+4
ALUSrc  output  1  0 rs2, 1 immediate
ALUctrl  output  4  ALU operation code (encoding below)
Branch  output  1  conditional branch
Jump  output  1  JAL or JALR
JumpReg  output  1  JALR (target = rs1 + imm)
BranchType  output  3  funct3 of the branch
illegal_o  output  1  unsupported opcode in a valid slot

Behaviour:
- Reset (asynchronous, rst_n=0):
  - PC = RESET_PC.
  - id_valid_o = 0; IF/ID instr = 32'h0000_0013 (NOP); id_pc_o = 0.
  - All control outputs and illegal_o are 0.
- Clock edge priority: flush_i > stall_i > normal.
  - flush_i=1: PC <= {pc_target_i[ADDRESS_WIDTH-1:2], 2'b00}; IF/ID <= NOP; id_valid_o <= 0. This applies even if stall_i=1.
  - stall_i=1 only: PC and IF/ID unchanged.
  - Normal: IF/ID <= {PC, imem_rdata_i}; id_valid_o <= 1; PC <= PC + 4.
- PC arithmetic wraps modulo 2^ADDRESS_WIDTH; no overflow flag.
- Latency: the instruction at PC appears on the decode outputs exactly 1 cycle after the edge that captures it.
- Decode is purely combinational from IF/ID.
  - When id_valid_o=0: RegWrite, MemWrite, Branch, Jump, JumpReg and illegal_o are forced to 0.
- Immediate formats:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All formats sign-extend from instr[31].
- ALUctrl encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
- Opcode decode:
  - R (0110011): funct7[5] selects sub/sra. RegWrite=1, ALUSrc=0.
  - I-ALU (0010011): as R, with ALUSrc=1. funct7[5] is honoured only for srai. addi is never decoded as sub.
  - Load (0000011): add, ALUSrc=1, ResultSrc=01, RegWrite=1.
  - Store (0100011): add, ALUSrc=1, MemWrite=1.
  - Branch (1100011): sub, Branch=1, BranchType=funct3, ALUSrc=0.
  - JAL (1101111): Jump=1, ResultSrc=10, RegWrite=1.
  - JALR (1100111): Jump=1, JumpReg=1, add, ALUSrc=1, ResultSrc=10, RegWrite=1.
  - LUI (0110111): passB, ALUSrc=1, RegWrite=1.
  - AUIPC (0010111): add, ALUSrc=1, RegWrite=1. The EX stage selects PC as operand A.
  - Any other opcode: illegal_o=1, all enables 0.
- rd=x0: RegWrite is still asserted as decoded; the register file discards the write.
- Reset released mid-stream: the first fetch after rst_n rises is at RESET_PC.

Test Plan:
- Reset, then 3 free-running cycles, imem returns addi x1,x0,5 (0x00500093) -> imem_addr_o 0,4,8,C; id_imm_o=5, ALUctrl=0000, RegWrite=1, ALUSrc=1.
- stall_i=1 for 2 cycles at PC=8 -> imem_addr_o stays 8; id_pc_o stays 4; outputs stable.
- flush_i=1 with pc_target_i=0x40 (stall_i also 1) -> next cycle PC=0x40, id_valid_o=0, RegWrite=0; target 0x43 yields PC=0x40.
- Decode beq x1,x2,-8 (0xFE208CE3) -> Branch=1, BranchType=000, ALUctrl=0001, id_imm_o=0xFFFFFFF8.
- Decode jal x1,+2048 (0x001000EF), sub (0x40208033), lui 0x12345 (0x123452B7) -> jal: id_imm_o=0x800, Jump=1, ResultSrc=10; sub: ALUctrl=0001; lui: id_imm_o=0x12345000, ALUctrl=1010.
- Opcode 0x7F fetched; PC=0xFFFFFFFC free-running -> illegal_o=1, RegWrite=0, MemWrite=0; next PC wraps to 0x00000000.

Source files
------------

// File: rtl/fetch_decode_stage_if.sv
// Bundle between the fetch/decode stage and its neighbours: hazard/branch control,
// instruction memory, and the decoded-instruction outputs toward the register file / ID/EX.
interface fetch_decode_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     stall_i;
    logic                     flush_i;
    logic [ADDRESS_WIDTH-1:0] pc_target_i;
    logic [ADDRESS_WIDTH-1:0] imem_addr_o;
    logic [DATA_WIDTH-1:0]    imem_rdata_i;
    logic                     id_valid_o;
    logic [ADDRESS_WIDTH-1:0] id_pc_o;
    logic [ADDRESS_WIDTH-1:0] id_pc_plus4_o;
    logic [4:0]               id_rs1_o;
    logic [4:0]               id_rs2_o;
    logic [4:0]               id_rd_o;
    logic [DATA_WIDTH-1:0]    id_imm_o;
    logic                     RegWrite;
    logic                     MemWrite;
    logic [1:0]               ResultSrc;
    logic                     ALUSrc;
    logic [3:0]               ALUctrl;
    logic                     Branch;
    logic                     Jump;
    logic                     JumpReg;
    logic [2:0]               BranchType;
    logic                     illegal_o;

    modport master (
        input  stall_i, flush_i, pc_target_i, imem_rdata_i,
        output imem_addr_o, id_valid_o, id_pc_o, id_pc_plus4_o,
               id_rs1_o, id_rs2_o, id_rd_o, id_imm_o,
               RegWrite, MemWrite, ResultSrc, ALUSrc, ALUctrl,
               Branch, Jump, JumpReg, BranchType, illegal_o
    );

    modport slave (
        output stall_i, flush_i, pc_target_i, imem_rdata_i,
        input  imem_addr_o, id_valid_o, id_pc_o, id_pc_plus4_o,
               id_rs1_o, id_rs2_o, id_rd_o, id_imm_o,
               RegWrite, MemWrite, ResultSrc, ALUSrc, ALUctrl,
               Branch, Jump, JumpReg, BranchType, illegal_o
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// RV32I fetch + decode stage: PC register, IF/ID pipeline register with stall/flush,
// and combinational decode of the registered instruction.
module fetch_decode_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_decode_stage_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010,
                           ALU_OR   = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101,
                           ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111, ALU_SRL  = 4'b1000,
                           ALU_SRA  = 4'b1001, ALU_PASSB = 4'b1010;

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] r_id_pc;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic                     r_id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_id_pc    <= '0;
            r_instr    <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (bus.flush_i) begin
            // Redirect wins over stall; the target is forced word-aligned.
            r_pc       <= {bus.pc_target_i[ADDRESS_WIDTH-1:2], 2'b00};
            r_id_pc    <= '0;
            r_instr    <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (!bus.stall_i) begin
            r_pc       <= r_pc + ADDRESS_WIDTH'(4);
            r_id_pc    <= r_pc;
            r_instr    <= bus.imem_rdata_i;
            r_id_valid <= 1'b1;
        end
    end

    function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_funct7_5;
    logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_funct7_5 = r_instr[30];

    assign w_imm_i = {{(DATA_WIDTH-12){r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s = {{(DATA_WIDTH-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b = {{(DATA_WIDTH-13){r_instr[31]}}, r_instr[31], r_instr[7],
                      r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_u = {r_instr[31:12], 12'b0};
    assign w_imm_j = {{(DATA_WIDTH-21){r_instr[31]}}, r_instr[31], r_instr[19:12],
                      r_instr[20], r_instr[30:21], 1'b0};

    logic                  w_reg_write, w_mem_write, w_alu_src;
    logic                  w_branch, w_jump, w_jump_reg, w_illegal;
    logic [1:0]            w_result_src;
    logic [3:0]            w_alu_ctrl;
    logic [2:0]            w_branch_type;
    logic [DATA_WIDTH-1:0] w_imm;

    always_comb begin
        w_reg_write   = 1'b0;
        w_mem_write   = 1'b0;
        w_alu_src     = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_jump_reg    = 1'b0;
        w_illegal     = 1'b0;
        w_result_src  = 2'b00;
        w_alu_ctrl    = ALU_ADD;
        w_branch_type = 3'b000;
        w_imm         = '0;
        case (w_opcode)
            OP_R: begin
                w_reg_write = 1'b1;
                w_alu_ctrl  = alu_op(w_funct3, w_funct7_5);
            end
            OP_I: begin
                // Only the shift-right slot uses funct7[5]; addi must never become sub.
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_ctrl  = alu_op(w_funct3, w_funct7_5 && (w_funct3 == 3'b101));
                w_imm       = w_imm_i;
            end
            OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b01;
                w_imm        = w_imm_i;
            end
            OP_STORE: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm       = w_imm_s;
            end
            OP_BRANCH: begin
                w_branch      = 1'b1;
                w_alu_ctrl    = ALU_SUB;
                w_branch_type = w_funct3;
                w_imm         = w_imm_b;
            end
            OP_JAL: begin
                w_jump       = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
                w_imm        = w_imm_j;
            end
            OP_JALR: begin
                w_jump       = 1'b1;
                w_jump_reg   = 1'b1;
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b10;
                w_imm        = w_imm_i;
            end
            OP_LUI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_ctrl  = ALU_PASSB;
                w_imm       = w_imm_u;
            end
            OP_AUIPC: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm       = w_imm_u;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign bus.imem_addr_o   = r_pc;
    assign bus.id_valid_o    = r_id_valid;
    assign bus.id_pc_o       = r_id_pc;
    assign bus.id_pc_plus4_o = r_id_pc + ADDRESS_WIDTH'(4);
    assign bus.id_rs1_o      = r_instr[19:15];
    assign bus.id_rs2_o      = r_instr[24:20];
    assign bus.id_rd_o       = r_instr[11:7];
    assign bus.id_imm_o      = w_imm;

    // An empty slot presents an all-zero control word.
    assign bus.RegWrite   = r_id_valid & w_reg_write;
    assign bus.MemWrite   = r_id_valid & w_mem_write;
    assign bus.ALUSrc     = r_id_valid & w_alu_src;
    assign bus.Branch     = r_id_valid & w_branch;
    assign bus.Jump       = r_id_valid & w_jump;
    assign bus.JumpReg    = r_id_valid & w_jump_reg;
    assign bus.illegal_o  = r_id_valid & w_illegal;
    assign bus.ResultSrc  = r_id_valid ? w_result_src : 2'b00;
    assign bus.ALUctrl    = r_id_valid ? w_alu_ctrl : ALU_ADD;
    assign bus.BranchType = r_id_valid ? w_branch_type : 3'b000;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed scoreboard bench for fetch_decode_stage: stimulus pushes hand-computed
// expectations, a monitor pops and compares them one cycle later.
module tb_fetch_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_decode_stage_if bus ();

    fetch_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic [31:0] target;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] id_pc;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [14:0] regs;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BEQ  = 32'hFE20_8CE3;
    localparam logic [31:0] JAL  = 32'h0010_00EF;
    localparam logic [31:0] SUB  = 32'h4020_8033;
    localparam logic [31:0] LUI  = 32'h1234_52B7;
    localparam logic [31:0] LW   = 32'h0040_A103;
    localparam logic [31:0] SW   = 32'h0020_A423;
    localparam logic [31:0] SRAI = 32'h4030_D093;
    localparam logic [31:0] ILL  = 32'h0000_007F;

    // {RegWrite, MemWrite, ResultSrc, ALUSrc, ALUctrl, Branch, Jump, JumpReg, BranchType, illegal}
    function automatic logic [15:0] mk(input logic rw, input logic mw, input logic [1:0] rs,
                                       input logic as, input logic [3:0] alu, input logic br,
                                       input logic j, input logic jr, input logic [2:0] bt,
                                       input logic ill);
        return {rw, mw, rs, as, alu, br, j, jr, bt, ill};
    endfunction

    function automatic logic [14:0] regs(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd);
        return {rs1, rs2, rd};
    endfunction

    task automatic add(input logic r, input logic st, input logic fl, input logic [31:0] tgt,
                       input logic [31:0] rd, input logic [31:0] pc, input logic v,
                       input logic [31:0] idpc, input logic [31:0] imm, input logic [15:0] c,
                       input logic [14:0] rg);
        vec_t e;
        e.rst_n = r; e.stall = st; e.flush = fl; e.target = tgt; e.rdata = rd;
        e.pc = pc; e.valid = v; e.id_pc = idpc; e.imm = imm; e.ctrl = c; e.regs = rg;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (txn %0d): got %h expected %h", name, n_txn, act, exp);
        end
    endtask

    // Monitor: one edge after each push, the DUT state must match the popped entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                vec_t e;
                logic [15:0] act_ctrl;
                e = sb.pop_front();
                n_txn++;
                act_ctrl = {bus.RegWrite, bus.MemWrite, bus.ResultSrc, bus.ALUSrc, bus.ALUctrl,
                            bus.Branch, bus.Jump, bus.JumpReg, bus.BranchType, bus.illegal_o};
                chk("imem_addr", bus.imem_addr_o, e.pc);
                chk("id_valid", 32'(bus.id_valid_o), 32'(e.valid));
                chk("id_imm", bus.id_imm_o, e.imm);
                chk("ctrl", 32'(act_ctrl), 32'(e.ctrl));
                chk("regs", 32'({bus.id_rs1_o, bus.id_rs2_o, bus.id_rd_o}), 32'(e.regs));
                if (e.valid) begin
                    chk("id_pc", bus.id_pc_o, e.id_pc);
                    chk("id_pc_plus4", bus.id_pc_plus4_o, e.id_pc + 32'd4);
                end
                $display("txn %0d: pc=%h valid=%b id_pc=%h imm=%h ctrl=%h", n_txn,
                         bus.imem_addr_o, bus.id_valid_o, bus.id_pc_o, bus.id_imm_o, act_ctrl);
            end
        end
    end

    initial begin
        logic [15:0] c_addi, c_beq, c_jal, c_sub, c_lui, c_lw, c_sw, c_srai, c_ill;
        c_addi = mk(1, 0, 2'b00, 1, 4'b0000, 0, 0, 0, 3'b000, 0);
        c_beq  = mk(0, 0, 2'b00, 0, 4'b0001, 1, 0, 0, 3'b000, 0);
        c_jal  = mk(1, 0, 2'b10, 0, 4'b0000, 0, 1, 0, 3'b000, 0);
        c_sub  = mk(1, 0, 2'b00, 0, 4'b0001, 0, 0, 0, 3'b000, 0);
        c_lui  = mk(1, 0, 2'b00, 1, 4'b1010, 0, 0, 0, 3'b000, 0);
        c_lw   = mk(1, 0, 2'b01, 1, 4'b0000, 0, 0, 0, 3'b000, 0);
        c_sw   = mk(0, 1, 2'b00, 1, 4'b0000, 0, 0, 0, 3'b000, 0);
        c_srai = mk(1, 0, 2'b00, 1, 4'b1001, 0, 0, 0, 3'b000, 0);
        c_ill  = mk(0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 3'b000, 1);

        //  rst st fl target        rdata  pc            v  id_pc         imm           ctrl    regs
        add(0, 0, 0, 32'h0,        ADDI, 32'h0,        0, 32'h0,        32'h0,        16'h0,  regs(0, 0, 0));
        add(0, 0, 0, 32'h0,        ADDI, 32'h0,        0, 32'h0,        32'h0,        16'h0,  regs(0, 0, 0));
        add(1, 0, 0, 32'h0,        ADDI, 32'h4,        1, 32'h0,        32'h5,        c_addi, regs(0, 5, 1));
        add(1, 0, 0, 32'h0,        ADDI, 32'h8,        1, 32'h4,        32'h5,        c_addi, regs(0, 5, 1));
        add(1, 1, 0, 32'h0,        ADDI, 32'h8,        1, 32'h4,        32'h5,        c_addi, regs(0, 5, 1));
        add(1, 1, 0, 32'h0,        ADDI, 32'h8,        1, 32'h4,        32'h5,        c_addi, regs(0, 5, 1));
        add(1, 0, 0, 32'h0,        ADDI, 32'hC,        1, 32'h8,        32'h5,        c_addi, regs(0, 5, 1));
        add(1, 1, 1, 32'h40,       ADDI, 32'h40,       0, 32'h0,        32'h0,        16'h0,  regs(0, 0, 0));
        add(1, 0, 0, 32'h0,        BEQ,  32'h44,       1, 32'h40,       32'hFFFFFFF8, c_beq,  regs(1, 2, 25));
        add(1, 0, 1, 32'h43,       ADDI, 32'h40,       0, 32'h0,        32'h0,        16'h0,  regs(0, 0, 0));
        add(1, 0, 0, 32'h0,        JAL,  32'h44,       1, 32'h40,       32'h800,      c_jal,  regs(0, 1, 1));
        add(1, 0, 0, 32'h0,        SUB,  32'h48,       1, 32'h44,       32'h0,        c_sub,  regs(1, 2, 0));
        add(1, 0, 0, 32'h0,        LUI,  32'h4C,       1, 32'h48,       32'h12345000, c_lui,  regs(8, 3, 5));
        add(1, 0, 0, 32'h0,        LW,   32'h50,       1, 32'h4C,       32'h4,        c_lw,   regs(1, 4, 2));
        add(1, 0, 0, 32'h0,        SW,   32'h54,       1, 32'h50,       32'h8,        c_sw,   regs(1, 2, 8));
        add(1, 0, 0, 32'h0,        SRAI, 32'h58,       1, 32'h54,       32'h403,      c_srai, regs(1, 3, 1));
        add(1, 0, 1, 32'hFFFFFFFC, ADDI, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        16'h0,  regs(0, 0, 0));
        add(1, 0, 0, 32'h0,        ILL,  32'h0,        1, 32'hFFFFFFFC, 32'h0,        c_ill,  regs(0, 0, 0));
        add(1, 0, 0, 32'h0,        ADDI, 32'h4,        1, 32'h0,        32'h5,        c_addi, regs(0, 5, 1));
        add(0, 0, 0, 32'h0,        ADDI, 32'h0,        0, 32'h0,        32'h0,        16'h0,  regs(0, 0, 0));
        add(1, 0, 0, 32'h0,        ADDI, 32'h4,        1, 32'h0,        32'h5,        c_addi, regs(0, 5, 1));

        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;
        bus.pc_target_i  = '0;
        bus.imem_rdata_i = ADDI;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n            = vecs[i].rst_n;
            bus.stall_i      = vecs[i].stall;
            bus.flush_i      = vecs[i].flush;
            bus.pc_target_i  = vecs[i].target;
            bus.imem_rdata_i = vecs[i].rdata;
            sb.push_back(vecs[i]);
        end

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
